soml_tx_mapper: RTL and testbench

Transmit-side bit-to-symbol mapper for the SOML link, the inverse of the receiver's output mapping. It collects a serial bitstream into 12-bit words {b1[7:0], b2[3:0]}. Each word becomes four 4-PAM indices (m_I_1, m_Q_1, m_I_2, m_Q_2, each 1..4) via inverse Bv Gray mapping, a spatial index q_idx (1..16), and the matching PAM amplitudes. It sits between the bit source and the modulator/antenna-select stage, with valid/ready handshakes on both sides.

---
 rtl/soml_tx_mapper.sv | 126 ++++++++++++
 tb/tb_soml_tx_mapper.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/soml_tx_mapper.sv
// SOML transmit mapper: packs a serial MSB-first bitstream into 12-bit words and
// maps each word to four Gray-coded 4-PAM indices/amplitudes plus a spatial index.

module soml_pam_lane #(
  parameter int N = 32
) (
  input  logic [1:0]          bits,
  output logic signed [N-1:0] m,
  output logic signed [N-1:0] a
);
  logic [2:0] idx;

  always_comb begin
    case (bits)
      2'b00:   idx = 3'd1;
      2'b01:   idx = 3'd2;
      2'b11:   idx = 3'd3;
      default: idx = 3'd4;
    endcase
    m = {{(N-3){1'b0}}, idx};
    a = m + m - N'(5);
  end
endmodule

module soml_tx_mapper #(
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_bit,
  input  logic                in_sof,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [N-1:0] m_I_1,
  output logic signed [N-1:0] m_Q_1,
  output logic signed [N-1:0] m_I_2,
  output logic signed [N-1:0] m_Q_2,
  output logic signed [N-1:0] a_I_1,
  output logic signed [N-1:0] a_Q_1,
  output logic signed [N-1:0] a_I_2,
  output logic signed [N-1:0] a_Q_2,
  output logic [4:0]          q_idx,
  output logic [15:0]         sym_cnt,
  output logic                out_valid,
  input  logic                out_ready
);
  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_WAIT    = 1'b1;

  logic [0:0]  st, st_nxt;
  logic [10:0] sr;
  logic [3:0]  cnt;
  logic [11:0] pend, word, ld_word;
  logic        acc, done, slot_free, load;
  logic [3:0][N-1:0] m_n, a_n, m_q, a_q;

  assign acc       = in_valid && in_ready;
  assign done      = acc && !in_sof && (cnt == 4'd11);
  assign slot_free = !out_valid || out_ready;
  assign word      = {sr, in_bit};
  assign load      = (done && slot_free) || (st == ST_WAIT && out_ready);
  assign ld_word   = (st == ST_WAIT) ? pend : word;

  always_comb begin
    st_nxt = st;
    if (st == ST_COLLECT && done && !slot_free) st_nxt = ST_WAIT;
    if (st == ST_WAIT && out_ready)             st_nxt = ST_COLLECT;
  end

  // lane l maps word bits [11-2l -: 2]: I1, Q1, I2, Q2
  for (genvar l = 0; l < 4; l++) begin : g_lane
    soml_pam_lane #(.N(N)) u_lane (
      .bits (ld_word[11-2*l -: 2]),
      .m    (m_n[l]),
      .a    (a_n[l])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_COLLECT;
      in_ready  <= 1'b1;
      sr        <= '0;
      cnt       <= '0;
      pend      <= '0;
      m_q       <= '0;
      a_q       <= '0;
      q_idx     <= '0;
      out_valid <= 1'b0;
      sym_cnt   <= '0;
    end else begin
      if (acc) begin
        if (in_sof) begin
          sr  <= {10'b0, in_bit};
          cnt <= 4'd1;
        end else if (cnt == 4'd11) begin
          cnt <= '0;
        end else begin
          sr  <= {sr[9:0], in_bit};
          cnt <= cnt + 4'd1;
        end
      end
      if (done && !slot_free) pend <= word;
      st       <= st_nxt;
      in_ready <= (st_nxt == ST_COLLECT);
      if (load) begin
        m_q       <= m_n;
        a_q       <= a_n;
        q_idx     <= {1'b0, ld_word[3:0]} + 5'd1;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) sym_cnt <= sym_cnt + 16'd1;
    end
  end

  assign m_I_1 = m_q[0];
  assign m_Q_1 = m_q[1];
  assign m_I_2 = m_q[2];
  assign m_Q_2 = m_q[3];
  assign a_I_1 = a_q[0];
  assign a_Q_1 = a_q[1];
  assign a_I_2 = a_q[2];
  assign a_Q_2 = a_q[3];
endmodule

// File: tb/tb_soml_tx_mapper.sv
// Scoreboard bench for soml_tx_mapper: a bit-level model pushes expected words,
// which are compared field by field whenever the DUT presents out_valid.

module tb_soml_tx_mapper;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_bit = 1'b0, in_sof = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic signed [N-1:0] m_I_1, m_Q_1, m_I_2, m_Q_2, a_I_1, a_Q_1, a_I_2, a_Q_2;
  logic [4:0]  q_idx;
  logic [15:0] sym_cnt;

  int n_vec = 0, n_err = 0;
  logic [11:0] q[$];
  logic [11:0] mw;
  int          mcnt;
  logic [15:0] exp_sym;

  always #5 clk = ~clk;

  soml_tx_mapper #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_sof(in_sof), .in_valid(in_valid),
    .in_ready(in_ready), .m_I_1(m_I_1), .m_Q_1(m_Q_1), .m_I_2(m_I_2), .m_Q_2(m_Q_2),
    .a_I_1(a_I_1), .a_Q_1(a_Q_1), .a_I_2(a_I_2), .a_Q_2(a_Q_2), .q_idx(q_idx),
    .sym_cnt(sym_cnt), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gray_idx(input logic [11:0] w, input int lane);
    logic [1:0] b;
    b = w[11-2*lane -: 2];
    case (b)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b11:   return 3;
      default: return 4;
    endcase
  endfunction

  task automatic chk_word(input logic [11:0] w);
    int e0, e1, e2, e3;
    e0 = gray_idx(w, 0); e1 = gray_idx(w, 1); e2 = gray_idx(w, 2); e3 = gray_idx(w, 3);
    chk("m_I_1", m_I_1, e0); chk("m_Q_1", m_Q_1, e1);
    chk("m_I_2", m_I_2, e2); chk("m_Q_2", m_Q_2, e3);
    chk("a_I_1", a_I_1, 2*e0-5); chk("a_Q_1", a_Q_1, 2*e1-5);
    chk("a_I_2", a_I_2, 2*e2-5); chk("a_Q_2", a_Q_2, 2*e3-5);
    chk("q_idx", q_idx, int'(w[3:0]) + 1);
  endtask

  task automatic model_reset();
    q.delete();
    mcnt = 0;
    mw = '0;
    exp_sym = '0;
  endtask

  // observe at negedge, then drive the inputs for the next rising edge
  task automatic step(input bit iv, input bit ib, input bit sof, input bit ordy);
    bit ov, exp_ir;
    @(negedge clk);
    ov = out_valid;
    exp_ir = (q.size() < 2);
    chk("out_valid", ov, q.size() > 0);
    chk("in_ready", in_ready, exp_ir);
    chk("sym_cnt", sym_cnt, exp_sym);
    if (ov && q.size() > 0) chk_word(q[0]);
    in_valid = iv; in_bit = ib; in_sof = sof; out_ready = ordy;
    if (ov && ordy) begin
      if (q.size() > 0) void'(q.pop_front());
      exp_sym++;
    end
    if (iv && exp_ir) begin
      if (sof) begin
        mw = {11'b0, ib}; mcnt = 1;
      end else if (mcnt == 11) begin
        q.push_back({mw[10:0], ib}); mcnt = 0;
      end else begin
        mw = {mw[10:0], ib}; mcnt++;
      end
    end
  endtask

  task automatic send_word(input logic [11:0] w, input bit sof, input bit ordy);
    for (int i = 0; i < 12; i++) step(1'b1, w[11-i], sof && (i == 0), ordy);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_irdy"}, in_ready, 1);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_sym"}, sym_cnt, 0);
    chk({tag, "_q"}, q_idx, 0);
    chk({tag, "_m"}, m_I_1 | m_Q_1 | m_I_2 | m_Q_2, 0);
    chk({tag, "_a"}, a_I_1 | a_Q_1 | a_I_2 | a_Q_2, 0);
  endtask

  // async reset between edges; inputs idle so nothing is accepted on release
  task automatic do_reset(input string tag);
    in_valid = 1'b0; out_ready = 1'b0; in_sof = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_vals(tag);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    rst = 1'b0;

    // basic word, pulse and count
    send_word(12'b0001_1011_0000, 1'b1, 1'b1);
    step(0, 0, 0, 1);
    chk("t1_mI1", m_I_1, 1); chk("t1_mQ1", m_Q_1, 2);
    chk("t1_mI2", m_I_2, 4); chk("t1_mQ2", m_Q_2, 3);
    chk("t1_aI1", a_I_1, -3); chk("t1_aI2", a_I_2, 3);
    chk("t1_q", q_idx, 1);
    step(0, 0, 0, 1);
    chk("t1_pulse", out_valid, 0); chk("t1_sym", sym_cnt, 1);

    send_word(12'hFFF, 1'b0, 1'b1);
    step(0, 0, 0, 1);
    chk("t2_m", m_Q_2, 3); chk("t2_a", a_I_1, 1); chk("t2_q", q_idx, 16);
    send_word(12'b0101_0101_0111, 1'b0, 1'b1);
    step(0, 0, 0, 1);
    chk("t3_m", m_I_2, 2); chk("t3_q", q_idx, 8);

    // misalignment: partial word dropped by sof
    for (int i = 0; i < 5; i++) step(1, i[0], 0, 1);
    send_word(12'b1001_0011_1010, 1'b1, 1'b1);
    step(0, 0, 0, 1);
    chk("mis_mI1", m_I_1, 4); chk("mis_mQ1", m_Q_1, 2);
    chk("mis_mI2", m_I_2, 1); chk("mis_mQ2", m_Q_2, 3);
    chk("mis_q", q_idx, 11);
    step(0, 0, 0, 1);

    // reset mid-word
    for (int i = 0; i < 7; i++) step(1, 1'b1, i == 0, 1);
    do_reset("rst7");

    // backpressure: two words back-to-back, second lands in WAIT
    send_word(12'b0001_1011_0000, 1'b1, 1'b0);
    send_word(12'hFFF, 1'b0, 1'b0);
    step(1, 1, 0, 0);
    chk("bp_irdy", in_ready, 0); chk("bp_hold", m_I_1, 1);
    step(0, 0, 0, 1);
    chk("bp_hold2", m_I_2, 4); chk("bp_sym0", sym_cnt, 0);
    step(0, 0, 0, 1);
    chk("bp_w2", m_I_1, 3); chk("bp_sym1", sym_cnt, 1);
    step(0, 0, 0, 1);
    chk("bp_sym2", sym_cnt, 2);

    // reset while in WAIT, then a clean word
    send_word(12'h5A5, 1'b1, 1'b0);
    send_word(12'h3C3, 1'b0, 1'b0);
    step(0, 0, 0, 0);
    chk("wr_irdy", in_ready, 0);
    do_reset("rstw");
    send_word(12'b1001_0011_1010, 1'b0, 1'b1);
    step(0, 0, 0, 1);
    chk("wr_mI1", m_I_1, 4); chk("wr_q", q_idx, 11);

    // random stream against the model
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 40) == 0, $urandom_range(0, 2) != 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    chk("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
